ddr3_port_arbiter: RTL
======================

// Module: ddr3_port_arbiter
// PURPOSE
//  Shares one DDR3 MIG user (app_*) interface between NUM_PORTS burst requesters (ISP frame writers/readers).
//  Round-robin arbitration per burst; issues write/read commands with app_rdy/app_wdf_rdy handshake.
//  Routes in-order read data back to the issuing port via an internal tag FIFO. Sits between per-port FIFO adapters and the MIG.
// PARAMETERS
//  NUM_PORTS  2    number of requesters (1..8)
//  ADDR_W     29   app_addr width
//  DATA_W     256  app data width (one beat = 8 DDR words, address step 8)
//  LEN_W      8    burst length field width, in beats
//  TAG_DEPTH  32   max outstanding read beats (power of 2)
// PORTS
//  ui_clk              in   1                  MIG user clock; sole clock
//  rst                 in   1                  synchronous, active-high reset
//  init_calib_complete in   1                  MIG calibration done
//  req_valid           in   NUM_PORTS          per-port burst request, held until req_ready
//  req_cmd             in   NUM_PORTS          per-port command: 0 write, 1 read
//  req_addr            in   NUM_PORTS*ADDR_W   per-port start address (port p at [p*ADDR_W +: ADDR_W])
//  req_len             in   NUM_PORTS*LEN_W    per-port beat count
//  req_ready           out  NUM_PORTS          one-cycle accept pulse (one-hot)
//  wr_data             in   NUM_PORTS*DATA_W   per-port write beat, show-ahead (valid when wr_data_req)
//  wr_data_req         out  NUM_PORTS          one-hot pulse: beat consumed this cycle
//  burst_done          out  NUM_PORTS          one-hot pulse on last command of a burst
//  rd_data             out  DATA_W             = app_rd_data
//  rd_valid            out  NUM_PORTS          one-hot: rd_data belongs to this port
//  err_rd_orphan       out  1                  sticky: read data returned with empty tag FIFO
//  app_addr/app_en/app_cmd[2:0]/app_wdf_wren/app_wdf_end/app_wdf_data  out  MIG command/write side
//  app_rdy/app_wdf_rdy/app_rd_data_valid/app_rd_data                   in   MIG status/read side
// BEHAVIOUR
//  Reset: state WAIT_CAL, rr pointer 0, tags flushed, err_rd_orphan 0; all outputs 0 (app_cmd 0) from next edge.
//  Reset mid-burst abandons the burst: no further beats, outstanding tags discarded.
//  FSM: WAIT_CAL -> ARB when init_calib_complete. ARB: grant = first req_valid at/after rr_ptr (cyclic);
//   grant latches addr/len/cmd, pulses req_ready[g] same cycle, rr_ptr <= g+1 mod NUM_PORTS, -> BURST.
//   No request: stay ARB. req_len==0: req_ready + burst_done pulse same cycle, stay ARB, no command.
//  BURST write: fire = app_rdy & app_wdf_rdy; app_en=app_wdf_wren=app_wdf_end=fire, wr_data_req[g]=fire,
//   app_wdf_data = wr_data[g] (combinational mux). BURST read: fire = app_rdy & !tag_full; app_en=fire, app_cmd=1.
//  app_en/app_wdf_wren/wr_data_req combinational from state and ready; app_addr = latched cur_addr.
//  On fire: cur_addr += 8 (wraps mod 2^ADDR_W), beat_cnt++; on fire with beat_cnt==len-1: burst_done[g], -> ARB.
//  Min spacing: first command earliest one cycle after req_ready; one idle ARB cycle between bursts.
//  Read tag FIFO: push port index on each read fire; pop on app_rd_data_valid; rd_valid = onehot(head)&app_rd_data_valid,
//   zero-latency. Simultaneous push/pop legal, count unchanged. Full: read fires stall (app_en low), no drop.
//  app_rd_data_valid with empty FIFO: rd_valid 0, err_rd_orphan set until rst.
//  Requests arriving in BURST wait; req_valid dropped before req_ready is not served. Writes not blocked by read tags.
// STRUCTURE
//  Package ddr3_arb_pkg: FSM state encodings, CMD_WR=3'd0/CMD_RD=3'd1, BURST_STEP=8, clog2 helper.
//  Sub-module ddr3_rd_tag_fifo: sync FIFO, width clog2(NUM_PORTS), depth TAG_DEPTH, full/empty/count.
//  Top: arbiter + burst counter FSM; no other hierarchy.
// TESTING
//  Hold calib=0 with req_valid=2'b11 for 50 cycles -> no req_ready, app_en stays 0; then calib=1 -> port0 granted first.
//  Port0 write len=4 addr=0x100, app_rdy=app_wdf_rdy=1 -> 4 app_en/app_wdf_wren pulses, addr 0x100,0x108,0x110,0x118, burst_done on 4th.
//  Both ports request continuously -> grants alternate 0,1,0,1; toggle app_rdy randomly -> beat counts exact, no extra wr_data_req.
//  Port1 read len=40, TAG_DEPTH=32, no read data returned -> exactly 32 commands then stall; return 8 beats -> rest issued, rd_valid=2'b10.
//  Interleave port0 read len=2 then port1 read len=3, return 5 beats -> rd_valid 01,01,10,10,10; addr 0x1FFFFFF8 len=2 -> second addr 0.
//  Assert rst mid-burst (beat 2 of 8) -> next cycle all outputs 0; app_rd_data_valid pulse then sets err_rd_orphan; len=0 -> req_ready+burst_done, no app_en.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 MIG port arbiter.
package ddr3_arb_pkg;

  // Arbiter FSM encoding; WAIT_CAL is the all-zero reset state.
  typedef enum logic [1:0] {
    ST_WAIT_CAL = 2'd0,
    ST_ARB      = 2'd1,
    ST_BURST    = 2'd2
  } arb_state_t;

  // MIG app_cmd encodings.
  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  // One 256-bit beat covers 8 DDR words, so the address advances by 8.
  localparam int BURST_STEP = 8;

  // Ceiling log2, never below 1 so single-entry indices still get a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/ddr3_rd_tag_fifo.sv
// Synchronous FIFO of port indices for in-order read-data routing.
// Pushes while full and pops while empty are ignored.
module ddr3_rd_tag_fifo
  import ddr3_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 32,
  localparam int AW = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage: no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Round-robin burst arbiter sharing one MIG app_* interface among
// NUM_PORTS requesters, with a tag FIFO steering read data back in order.
//
// Handshakes: req_valid is held by the requester until the one-cycle
// req_ready pulse; a command transfers to the MIG in any cycle where
// app_en is high and app_rdy (plus app_wdf_rdy for writes) is high, and
// app_en is only raised in such cycles, so app_en itself marks a transfer.
module ddr3_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 29,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 8,
  parameter int TAG_DEPTH = 32
) (
  input  logic                        ui_clk,
  input  logic                        rst,
  input  logic                        init_calib_complete,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_cmd,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
  output logic [NUM_PORTS-1:0]        wr_data_req,
  output logic [NUM_PORTS-1:0]        burst_done,
  output logic [DATA_W-1:0]           rd_data,
  output logic [NUM_PORTS-1:0]        rd_valid,
  output logic                        err_rd_orphan,
  output logic [ADDR_W-1:0]           app_addr,
  output logic                        app_en,
  output logic [2:0]                  app_cmd,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  output logic [DATA_W-1:0]           app_wdf_data,
  input  logic                        app_rdy,
  input  logic                        app_wdf_rdy,
  input  logic                        app_rd_data_valid,
  input  logic [DATA_W-1:0]           app_rd_data,
  output arb_state_t                  fsm_state
);

  localparam int PW  = clog2_min1(NUM_PORTS);
  localparam int TAW = clog2_min1(TAG_DEPTH);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      cur_port;
  logic [ADDR_W-1:0]  cur_addr;
  logic [LEN_W-1:0]   cur_len;
  logic               cur_cmd;
  logic [LEN_W-1:0]   beat_cnt;

  logic               grant_any;
  logic [PW-1:0]      grant_idx;
  logic [ADDR_W-1:0]  grant_addr;
  logic [LEN_W-1:0]   grant_len;
  logic               fire;
  logic               wr_fire;

  logic [PW-1:0]      tag_head;
  logic               tag_full;
  logic               tag_empty;
  logic [TAW:0]       tag_count;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PW-1:0] p);
    port_onehot    = '0;
    port_onehot[p] = 1'b1;
  endfunction

  // Cyclic priority search: first requester at or after rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_any && req_valid[(int'(rr_ptr) + i) % NUM_PORTS]) begin
        grant_any = 1'b1;
        grant_idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      end
    end
  end

  assign grant_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign grant_len  = req_len[grant_idx*LEN_W +: LEN_W];

  // Next state, grant/done pulses and the per-beat fire condition.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    burst_done = '0;
    fire       = 1'b0;
    case (state_q)
      ST_WAIT_CAL: begin
        if (init_calib_complete) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (grant_any) begin
          req_ready[grant_idx] = 1'b1;
          // A zero-length burst is acknowledged and completed on the spot.
          if (grant_len == '0) burst_done[grant_idx] = 1'b1;
          else                 state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        fire = cur_cmd ? (app_rdy & ~tag_full) : (app_rdy & app_wdf_rdy);
        if (fire && (beat_cnt == cur_len - LEN_W'(1))) begin
          burst_done[cur_port] = 1'b1;
          state_d              = ST_ARB;
        end
      end
      default: state_d = ST_WAIT_CAL;
    endcase
  end

  assign wr_fire      = fire & ~cur_cmd;
  assign app_en       = fire;
  assign app_cmd      = (state_q == ST_BURST && cur_cmd) ? CMD_RD : CMD_WR;
  assign app_addr     = cur_addr;
  assign app_wdf_wren = wr_fire;
  assign app_wdf_end  = wr_fire;
  assign wr_data_req  = wr_fire ? port_onehot(cur_port) : '0;
  assign app_wdf_data = (state_q == ST_BURST && !cur_cmd) ?
                        wr_data[cur_port*DATA_W +: DATA_W] : '0;
  assign fsm_state    = state_q;

  // FSM state, burst context latched at grant, address/beat advance.
  always_ff @(posedge ui_clk) begin
    if (rst) begin
      state_q       <= ST_WAIT_CAL;
      rr_ptr        <= '0;
      cur_port      <= '0;
      cur_addr      <= '0;
      cur_len       <= '0;
      cur_cmd       <= 1'b0;
      beat_cnt      <= '0;
      err_rd_orphan <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ARB && grant_any) begin
        rr_ptr   <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
        cur_port <= grant_idx;
        cur_addr <= grant_addr;
        cur_len  <= grant_len;
        cur_cmd  <= req_cmd[grant_idx];
        beat_cnt <= '0;
      end
      if (fire) begin
        cur_addr <= cur_addr + ADDR_W'(BURST_STEP);
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (app_rd_data_valid && tag_count == '0) err_rd_orphan <= 1'b1;
    end
  end

  ddr3_rd_tag_fifo #(
    .WIDTH (PW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (ui_clk),
    .rst       (rst),
    .push      (fire & cur_cmd),
    .push_data (cur_port),
    .pop       (app_rd_data_valid),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  assign rd_data  = app_rd_data;
  assign rd_valid = (app_rd_data_valid && !tag_empty) ? port_onehot(tag_head) : '0;

endmodule
